// File: rtl/bus_read_sequencer_if.sv
// Request/response and shared-bus signals of the read sequencer.
// The master modport is the sequencer side; slave is the CPU/bus-register side.
interface bus_read_sequencer_if #(
    parameter int NrOfBits   = 8,
    parameter int NrOfSlaves = 4,
    parameter int AddrBits   = 2
);
    logic                  ReqValid;
    logic [AddrBits-1:0]   ReqAddr;
    logic                  ReqReady;
    logic [NrOfBits-1:0]   BusData;
    logic [NrOfSlaves-1:0] cs_n;
    logic                  RspValid;
    logic [NrOfBits-1:0]   RspData;
    logic                  RspError;
    logic                  RspReady;

    modport master (
        input  ReqValid, ReqAddr, BusData, RspReady,
        output ReqReady, cs_n, RspValid, RspData, RspError
    );

    modport slave (
        output ReqValid, ReqAddr, BusData, RspReady,
        input  ReqReady, cs_n, RspValid, RspData, RspError
    );
endinterface

// File: rtl/bus_read_sequencer.sv
// Read-side master for the shared tri-state register bus: one select at a time,
// settle, sample, release guard cycle, then a held valid/ready response.
module bus_read_sequencer #(
    parameter int NrOfBits         = 8,
    parameter int NrOfSlaves       = 4,
    parameter int AddrBits         = 2,
    parameter int TurnaroundCycles = 1
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      Tick,
    bus_read_sequencer_if.master      bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        SAMPLE  = 3'd2,
        RELEASE = 3'd3,
        RESP    = 3'd4
    } state_e;

    // One extra bit so NrOfSlaves itself is representable at the compare width.
    localparam logic [AddrBits:0] SlaveLimit = (AddrBits+1)'(NrOfSlaves);
    localparam logic [3:0]        SettleLast = 4'(TurnaroundCycles - 1);

    state_e                state_q, state_d;
    logic [3:0]            settle_q, settle_d;
    logic [NrOfSlaves-1:0] cs_n_q, cs_n_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [NrOfBits-1:0]   rsp_data_q, rsp_data_d;
    logic                  rsp_error_q, rsp_error_d;

    logic                  req_ready;
    logic                  accept;
    logic                  addr_ok;
    logic [NrOfSlaves-1:0] sel_n;

    assign req_ready = (state_q == IDLE);
    assign accept    = bus.ReqValid && req_ready && Tick;
    assign addr_ok   = ({1'b0, bus.ReqAddr} < SlaveLimit);

    always_comb begin
        for (int i = 0; i < NrOfSlaves; i++) begin
            sel_n[i] = ({1'b0, bus.ReqAddr} != (AddrBits+1)'(i));
        end
    end

    // State register plus all registered outputs; reset frees the bus at once.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            cs_n_q      <= '1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = addr_ok ? SELECT : RESP;
            SELECT:  if (Tick && (settle_q >= SettleLast)) state_d = SAMPLE;
            SAMPLE:  if (Tick) state_d = RELEASE;
            RELEASE: if (Tick) state_d = RESP;
            RESP:    if (rsp_valid_q && bus.RspReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        settle_d    = settle_q;
        cs_n_d      = cs_n_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    settle_d = '0;
                    if (addr_ok) begin
                        cs_n_d = sel_n;
                    end else begin
                        // Bad address answers straight away and never touches the bus.
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_data_d  = '0;
                    end
                end
            end
            SELECT: begin
                if (Tick && (settle_q != 4'hF)) settle_d = settle_q + 4'd1;
            end
            SAMPLE: begin
                if (Tick) begin
                    rsp_data_d = bus.BusData;
                    cs_n_d     = '1;
                end
            end
            RELEASE: begin
                if (Tick) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                end
            end
            RESP: begin
                if (rsp_valid_q && bus.RspReady) begin
                    rsp_valid_d = 1'b0;
                    rsp_error_d = 1'b0;
                end
            end
            default: begin
                cs_n_d      = '1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.ReqReady = req_ready;
    assign bus.cs_n     = cs_n_q;
    assign bus.RspValid = rsp_valid_q;
    assign bus.RspData  = rsp_data_q;
    assign bus.RspError = rsp_error_q;

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Bench for bus_read_sequencer: a default instance and one with AddrBits=3,
// TurnaroundCycles=2, checked per cycle against tick-count timing rules.
module tb_bus_read_sequencer;

    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       tick      [2];
    logic       req_valid [2];
    logic       rsp_ready [2];
    logic [2:0] req_addr  [2];
    logic [7:0] slv       [2][4];
    logic [7:0] bus_data  [2];

    logic       req_ready [2];
    logic       rsp_valid [2];
    logic       rsp_error [2];
    logic [7:0] rsp_data  [2];
    logic [3:0] cs_n      [2];

    int checks = 0;
    int errors = 0;

    bus_read_sequencer_if #(.NrOfBits(8), .NrOfSlaves(4), .AddrBits(2)) if0 ();
    bus_read_sequencer_if #(.NrOfBits(8), .NrOfSlaves(4), .AddrBits(3)) if1 ();

    assign if0.ReqValid = req_valid[0];
    assign if0.ReqAddr  = req_addr[0][1:0];
    assign if0.BusData  = bus_data[0];
    assign if0.RspReady = rsp_ready[0];
    assign req_ready[0] = if0.ReqReady;
    assign rsp_valid[0] = if0.RspValid;
    assign rsp_error[0] = if0.RspError;
    assign rsp_data[0]  = if0.RspData;
    assign cs_n[0]      = if0.cs_n;

    assign if1.ReqValid = req_valid[1];
    assign if1.ReqAddr  = req_addr[1];
    assign if1.BusData  = bus_data[1];
    assign if1.RspReady = rsp_ready[1];
    assign req_ready[1] = if1.ReqReady;
    assign rsp_valid[1] = if1.RspValid;
    assign rsp_error[1] = if1.RspError;
    assign rsp_data[1]  = if1.RspData;
    assign cs_n[1]      = if1.cs_n;

    bus_read_sequencer #(.NrOfBits(8), .NrOfSlaves(4), .AddrBits(2), .TurnaroundCycles(1)) u_dut0 (
        .Clock(clk), .Reset_n(rst_n), .Tick(tick[0]), .bus(if0)
    );

    bus_read_sequencer #(.NrOfBits(8), .NrOfSlaves(4), .AddrBits(3), .TurnaroundCycles(2)) u_dut1 (
        .Clock(clk), .Reset_n(rst_n), .Tick(tick[1]), .bus(if1)
    );

    // Bus registers: the selected one drives its word, EE stands in for a floating bus.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            bus_data[d] = 8'hEE;
            for (int i = 0; i < NS; i++) begin
                if (!cs_n[d][i]) bus_data[d] = slv[d][i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One read on instance d. Expected timing is counted in Tick edges since accept:
    // select held for tc+1 ticks, valid after tc+2 ticks; bad address valid at once.
    task automatic read_txn(input int d, input int addr, input int p, input int hold);
        int         tc    = (d == 0) ? 1 : 2;
        bit         inr   = (addr < NS);
        logic [7:0] exp_d = inr ? slv[d][addr[1:0]] : 8'h00;
        logic [3:0] sel   = inr ? ~(4'b0001 << addr) : 4'hF;
        logic [3:0] exp_cs;
        bit         exp_v;
        int         ph    = $urandom_range(p - 1, 0);
        int         k     = 0;
        int         n     = 0;
        bit         acc   = 1'b0;
        bit         done  = 1'b0;

        while (!acc && n < 50) begin
            @(negedge clk);
            req_valid[d] = 1'b1;
            req_addr[d]  = 3'(addr);
            rsp_ready[d] = (hold == 0);
            tick[d]      = ((ph % p) == 0);
            ph++;
            chk("req_ready_idle", 32'(req_ready[d]), 32'(1));
            @(posedge clk); #1;
            n++;
            if (tick[d]) acc = 1'b1;
            else chk("cs_n_idle", 32'(cs_n[d]), 32'(4'hF));
        end
        if (!acc) begin
            chk("accept_timeout", 32'(0), 32'(1));
            return;
        end

        n = 0;
        while (!done && n < 200) begin
            exp_v  = inr ? (k >= tc + 2) : 1'b1;
            exp_cs = (inr && k < tc + 1) ? sel : 4'hF;
            chk("cs_n", 32'(cs_n[d]), 32'(exp_cs));
            chk("rsp_valid", 32'(rsp_valid[d]), 32'(exp_v));
            if (exp_v) begin
                done = 1'b1;
            end else begin
                chk("req_ready_busy", 32'(req_ready[d]), 32'(0));
                @(negedge clk);
                tick[d]      = ((ph % p) == 0);
                ph++;
                req_valid[d] = 1'($urandom);
                req_addr[d]  = 3'($urandom);
                @(posedge clk); #1;
                if (tick[d]) k++;
                n++;
            end
        end
        if (!done) chk("rsp_timeout", 32'(0), 32'(1));
        chk("rsp_data", 32'(rsp_data[d]), 32'(exp_d));
        chk("rsp_error", 32'(rsp_error[d]), 32'(!inr));

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            tick[d]      = 1'($urandom);
            req_valid[d] = 1'($urandom);
            req_addr[d]  = 3'($urandom);
            rsp_ready[d] = 1'b0;
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid[d]), 32'(1));
            chk("hold_data", 32'(rsp_data[d]), 32'(exp_d));
            chk("hold_error", 32'(rsp_error[d]), 32'(!inr));
            chk("hold_req_ready", 32'(req_ready[d]), 32'(0));
            chk("hold_cs_n", 32'(cs_n[d]), 32'(4'hF));
        end

        @(negedge clk);
        rsp_ready[d] = 1'b1;
        req_valid[d] = 1'b0;
        tick[d]      = 1'($urandom);
        @(posedge clk); #1;
        chk("done_valid", 32'(rsp_valid[d]), 32'(0));
        chk("done_error", 32'(rsp_error[d]), 32'(0));
        chk("done_data_kept", 32'(rsp_data[d]), 32'(exp_d));
        chk("done_req_ready", 32'(req_ready[d]), 32'(1));
        chk("done_cs_n", 32'(cs_n[d]), 32'(4'hF));
        @(negedge clk);
        rsp_ready[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            tick[d] = 1'b0; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0; req_addr[d] = '0;
            for (int i = 0; i < NS; i++) slv[d][i] = 8'(i);
        end

        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_cs_n", 32'(cs_n[d]), 32'(4'hF));
            chk("rst_valid", 32'(rsp_valid[d]), 32'(0));
            chk("rst_data", 32'(rsp_data[d]), 32'(0));
            chk("rst_error", 32'(rsp_error[d]), 32'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready0", 32'(req_ready[0]), 32'(1));
        chk("rst_req_ready1", 32'(req_ready[1]), 32'(1));

        slv[0][2] = 8'hA5;
        read_txn(0, 2, 1, 0);
        read_txn(0, 3, 1, 5);
        read_txn(1, 6, 1, 0);
        slv[1][0] = 8'h3C;
        read_txn(1, 0, 3, 0);

        // Reset asserted between clock edges while addr 1 is selected.
        slv[0][1] = 8'h96;
        @(negedge clk);
        req_valid[0] = 1'b1; req_addr[0] = 3'd1; tick[0] = 1'b1; rsp_ready[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_sel_cs_n", 32'(cs_n[0]), 32'(4'b1101));
        req_valid[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cs_n", 32'(cs_n[0]), 32'(4'hF));
        chk("async_rst_valid", 32'(rsp_valid[0]), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_ready", 32'(req_ready[0]), 32'(1));
        read_txn(0, 1, 1, 0);

        for (int i = 0; i < NS; i++) slv[0][i] = 8'(i * 8'h11);
        for (int i = 0; i < NS; i++) read_txn(0, i, 1, 0);

        for (int t = 0; t < 40; t++) begin
            int d    = $urandom_range(1, 0);
            int addr = (d == 0) ? $urandom_range(3, 0) : $urandom_range(7, 0);
            for (int i = 0; i < NS; i++) slv[d][i] = 8'($urandom);
            read_txn(d, addr, $urandom_range(3, 1), $urandom_range(4, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
